// File: rtl/eth_tx_frame_ctrl.sv
// Transmit frame controller: pops a frame code, emits a 4-word Ethernet header, then payload or zeros, padded to 15 words.
// Optional frame statistics counters are built when ETH_TX_CTRL_STATS_EN is defined.
module eth_tx_frame_ctrl #(
  parameter int          PAYLOAD_WORDS = 16,
  parameter logic [15:0] ETHERTYPE     = 16'h88B5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic        frame_available,
  input  logic [2:0]  frame,
  output logic        sched_read,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic [1:0]  tx_empty,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] stat_data_frames,
  output logic [15:0] stat_err_frames
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, PAD} state_t;

  localparam logic [8:0] HDR_LAST = 9'd3;
  localparam logic [8:0] PAY_LAST = 9'(3 + PAYLOAD_WORDS);
  localparam logic [8:0] MIN_LAST = 9'd14;
  localparam bit         NEED_PAD = (PAYLOAD_WORDS + 4) < 15;

  state_t      r_state;
  logic [8:0]  r_word_cnt;
  logic [2:0]  r_cur_frame;

  logic        w_valid_code;
  logic        w_is_data;
  logic        w_accept;

  always_comb begin
    case (frame)
      3'b001, 3'b011, 3'b010, 3'b110: w_valid_code = 1'b1;
      default:                        w_valid_code = 1'b0;
    endcase
  end

  assign w_is_data = (r_cur_frame == 3'b001);
  assign busy      = (r_state != IDLE);
  assign tx_empty  = 2'b00;

  always_comb begin
    sched_read = 1'b0;
    tx_valid   = 1'b0;
    tx_sop     = 1'b0;
    tx_eop     = 1'b0;
    tx_data    = 32'h0;
    data_ready = 1'b0;
    case (r_state)
      IDLE: begin
        sched_read = frame_available && !rst;
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_sop   = (r_word_cnt == 9'd0);
        case (r_word_cnt[1:0])
          2'd0:    tx_data = dst_mac[47:16];
          2'd1:    tx_data = {dst_mac[15:0], src_mac[47:32]};
          2'd2:    tx_data = src_mac[31:0];
          default: tx_data = {ETHERTYPE, 5'b0, r_cur_frame, 8'h00};
        endcase
      end
      PAYLOAD: begin
        // Payload is a straight pass-through, so bubbles from the buffer reach the MAC as-is
        tx_data    = data_in;
        tx_valid   = data_valid;
        data_ready = tx_ready;
        tx_eop     = data_valid && !NEED_PAD && (r_word_cnt == PAY_LAST);
      end
      PAD: begin
        tx_valid = 1'b1;
        tx_eop   = (r_word_cnt == MIN_LAST);
      end
      default: ;
    endcase
  end

  assign w_accept = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_word_cnt  <= 9'd0;
      r_cur_frame <= 3'b000;
    end else begin
      case (r_state)
        IDLE: begin
          if (frame_available) begin
            r_cur_frame <= frame;
            r_word_cnt  <= 9'd0;
            if (w_valid_code) r_state <= HDR;
          end
        end
        HDR: begin
          if (w_accept) begin
            r_word_cnt <= r_word_cnt + 9'd1;
            if (r_word_cnt == HDR_LAST) r_state <= w_is_data ? PAYLOAD : PAD;
          end
        end
        PAYLOAD: begin
          if (w_accept) begin
            r_word_cnt <= r_word_cnt + 9'd1;
            if (r_word_cnt == PAY_LAST) r_state <= NEED_PAD ? PAD : IDLE;
          end
        end
        PAD: begin
          if (w_accept) begin
            r_word_cnt <= r_word_cnt + 9'd1;
            if (r_word_cnt == MIN_LAST) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ETH_TX_CTRL_STATS_EN
  logic [15:0] r_stat_data;
  logic [15:0] r_stat_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_data <= 16'h0;
      r_stat_err  <= 16'h0;
    end else if (w_accept && tx_eop) begin
      if (w_is_data) r_stat_data <= r_stat_data + 16'h1;
      else           r_stat_err  <= r_stat_err + 16'h1;
    end
  end

  assign stat_data_frames = r_stat_data;
  assign stat_err_frames  = r_stat_err;
`else
  assign stat_data_frames = 16'h0;
  assign stat_err_frames  = 16'h0;
`endif

endmodule

// File: tb/tb_eth_tx_frame_ctrl.sv
// Bench for eth_tx_frame_ctrl: two instances (16-word and 4-word payload) checked against a frame-list reference model.
// Stats expectations follow ETH_TX_CTRL_STATS_EN.
module tb_eth_tx_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] dstMac, srcMac;
  logic        fAvail[2];
  logic [2:0]  frameIn[2];
  logic        schedRead[2];
  logic [31:0] dataIn[2];
  logic        dataValid[2];
  logic        dataReady[2];
  logic [31:0] txData[2];
  logic        txValid[2], txSop[2], txEop[2], txReady[2], busy[2];
  logic [1:0]  txEmpty[2];
  logic [15:0] statData[2], statErr[2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [2:0]  fifoQ[$];
  logic [33:0] expQ[$];
  logic [33:0] gotQ[$];
  logic [31:0] payStream[$];
  int          payIdx = 0;
  int          modelPayIdx = 0;
  int          statD[2];
  int          statE[2];
  int          pushCount, popCount, drCount, pendSop, lastEop;
  bit          stallPrev;
  logic [33:0] prevBeat;

  always #5 clk = ~clk;

  eth_tx_frame_ctrl #(.PAYLOAD_WORDS(16)) dut16 (
    .clk(clk), .rst(rst), .dst_mac(dstMac), .src_mac(srcMac),
    .frame_available(fAvail[0]), .frame(frameIn[0]), .sched_read(schedRead[0]),
    .data_in(dataIn[0]), .data_valid(dataValid[0]), .data_ready(dataReady[0]),
    .tx_data(txData[0]), .tx_valid(txValid[0]), .tx_sop(txSop[0]), .tx_eop(txEop[0]),
    .tx_empty(txEmpty[0]), .tx_ready(txReady[0]), .busy(busy[0]),
    .stat_data_frames(statData[0]), .stat_err_frames(statErr[0])
  );

  eth_tx_frame_ctrl #(.PAYLOAD_WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .dst_mac(dstMac), .src_mac(srcMac),
    .frame_available(fAvail[1]), .frame(frameIn[1]), .sched_read(schedRead[1]),
    .data_in(dataIn[1]), .data_valid(dataValid[1]), .data_ready(dataReady[1]),
    .tx_data(txData[1]), .tx_valid(txValid[1]), .tx_sop(txSop[1]), .tx_eop(txEop[1]),
    .tx_empty(txEmpty[1]), .tx_ready(txReady[1]), .busy(busy[1]),
    .stat_data_frames(statData[1]), .stat_err_frames(statErr[1])
  );

  task automatic checkResult(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int payloadWords(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  // Reference model: the whole frame is written out as a list of {sop, eop, word}
  task automatic addFrame(input int k, input logic [2:0] code);
    logic [31:0] w[$];
    int len;
    fifoQ.push_back(code);
    pushCount++;
    if (code == 3'b001 || code == 3'b011 || code == 3'b010 || code == 3'b110) begin
      w.push_back(dstMac[47:16]);
      w.push_back({dstMac[15:0], srcMac[47:32]});
      w.push_back(srcMac[31:0]);
      w.push_back({16'h88B5, 5'b0, code, 8'h00});
      len = 15;
      if (code == 3'b001) begin
        if (4 + payloadWords(k) > 15) len = 4 + payloadWords(k);
        for (int i = 0; i < payloadWords(k); i++) begin
          while (payStream.size() <= modelPayIdx) payStream.push_back($urandom);
          w.push_back(payStream[modelPayIdx]);
          modelPayIdx++;
        end
        statD[k]++;
      end else begin
        statE[k]++;
      end
      while (w.size() < len) w.push_back(32'h0);
      for (int i = 0; i < len; i++) expQ.push_back({i == 0, i == len - 1, w[i]});
    end
  endtask

  task automatic applyStimulus(input int k, input int mode, input int n);
    for (int j = 0; j < 2; j++) begin
      fAvail[j] = 1'b0; frameIn[j] = 3'b000; dataIn[j] = 32'h0; dataValid[j] = 1'b0; txReady[j] = 1'b0;
    end
    fAvail[k]  = (fifoQ.size() != 0);
    frameIn[k] = (fifoQ.size() != 0) ? fifoQ[0] : 3'b000;
    dataIn[k]  = (payIdx < payStream.size()) ? payStream[payIdx] : 32'h0;
    case (mode)
      0: begin txReady[k] = 1'b1; dataValid[k] = 1'b1; end
      1: begin txReady[k] = n[0]; dataValid[k] = (n % 3) != 2; end
      default: begin
        txReady[k]   = $urandom_range(0, 3) != 0;
        dataValid[k] = $urandom_range(0, 3) != 0;
      end
    endcase
  endtask

  task automatic observe(input int k);
    logic [33:0] beat;
    beat = {txSop[k], txEop[k], txData[k]};
    if (pendSop >= 0 && cyc == pendSop) begin
      checkResult("sopLatency", {txValid[k], txSop[k]}, 2'b11);
      pendSop = -1;
    end
    if (stallPrev && txValid[k]) checkResult("stallStable", beat, prevBeat);
    stallPrev = txValid[k] && !txReady[k];
    prevBeat  = beat;
    if (txValid[k] && txReady[k]) begin
      gotQ.push_back(beat);
      if (txSop[k] && lastEop >= 0) checkResult("idleGap", (cyc - lastEop) >= 2, 1);
      if (txEop[k]) lastEop = cyc;
    end
    if (dataReady[k]) drCount++;
    if (dataReady[k] && dataValid[k]) payIdx++;
    if (schedRead[k]) begin
      logic [2:0] code;
      code = fifoQ.pop_front();
      popCount++;
      if (code == 3'b001 || code == 3'b011 || code == 3'b010 || code == 3'b110) pendSop = cyc + 1;
    end
  endtask

  task automatic checkOutput(input int k);
    int n;
    checkResult("beatCount", gotQ.size(), expQ.size());
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) checkResult("beat", gotQ[i], expQ[i]);
    checkResult("pops", popCount, pushCount);
    checkResult("consumed", payIdx, modelPayIdx);
`ifdef ETH_TX_CTRL_STATS_EN
    checkResult("statData", statData[k], 16'(statD[k]));
    checkResult("statErr", statErr[k], 16'(statE[k]));
`else
    checkResult("statData", statData[k], 0);
    checkResult("statErr", statErr[k], 0);
`endif
  endtask

  task automatic runSequence(input int k, input int mode, input int resetAtBeat);
    bit done;
    done = 0;
    gotQ.delete();
    pendSop = -1; lastEop = -1; stallPrev = 0; drCount = 0; popCount = 0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(posedge clk); #1; cyc++;
      applyStimulus(k, mode, n);
      @(negedge clk);
      observe(k);
      if (resetAtBeat >= 0 && gotQ.size() == resetAtBeat + 1) begin
        rst = 1'b1;
        @(posedge clk); #1; cyc++;
        rst = 1'b0;
        applyStimulus(k, mode, n + 1);
        @(negedge clk);
        checkResult("rstValid", txValid[k], 0);
        checkResult("rstBusy", busy[k], 0);
        checkResult("rstNoEop", gotQ[resetAtBeat][32], 0);
        expQ.delete(); gotQ.delete();
        statD = '{0, 0}; statE = '{0, 0};
        pushCount = 0;
        return;
      end
      if (fifoQ.size() == 0 && !busy[k] && !schedRead[k]) done = 1;
    end
    if (!done) checkResult("timeout", 0, 1);
    checkOutput(k);
    expQ.delete();
    pushCount = 0;
  endtask

  initial begin
    rst = 1'b1;
    dstMac = {$urandom, $urandom};
    srcMac = {$urandom, $urandom};
    statD = '{0, 0}; statE = '{0, 0};
    pushCount = 0;
    for (int j = 0; j < 2; j++) begin
      fAvail[j] = 1'b0; frameIn[j] = 3'b000; dataIn[j] = 32'h0; dataValid[j] = 1'b0; txReady[j] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      checkResult("rstTxValid", txValid[j], 0);
      checkResult("rstSop", txSop[j], 0);
      checkResult("rstEop", txEop[j], 0);
      checkResult("rstData", txData[j], 0);
      checkResult("rstReady", dataReady[j], 0);
      checkResult("rstBusy", busy[j], 0);
      checkResult("rstPop", schedRead[j], 0);
      checkResult("rstEmpty", txEmpty[j], 0);
      checkResult("rstStatD", statData[j], 0);
      checkResult("rstStatE", statErr[j], 0);
    end
    rst = 1'b0;

    $display("[TB] dim-error frame");
    addFrame(0, 3'b011);
    runSequence(0, 0, -1);

    $display("[TB] 16-word data frame");
    addFrame(0, 3'b001);
    runSequence(0, 0, -1);
    checkResult("readyCycles16", drCount, 16);

    $display("[TB] 4-word data frame with padding");
    addFrame(1, 3'b001);
    runSequence(1, 0, -1);
    checkResult("readyCycles4", drCount, 4);

    $display("[TB] backpressure");
    addFrame(0, 3'b001);
    addFrame(0, 3'b011);
    runSequence(0, 1, -1);
    addFrame(1, 3'b001);
    addFrame(1, 3'b110);
    runSequence(1, 1, -1);

    $display("[TB] back-to-back");
    addFrame(0, 3'b001);
    addFrame(0, 3'b010);
    addFrame(0, 3'b110);
    addFrame(0, 3'b000);
    runSequence(0, 0, -1);

    $display("[TB] reset mid-header");
    addFrame(0, 3'b011);
    runSequence(0, 0, 2);
    addFrame(0, 3'b011);
    runSequence(0, 0, -1);

    $display("[TB] random traffic");
    for (int r = 0; r < 8; r++) begin
      int k;
      int nf;
      k = r % 2;
      dstMac = {$urandom, $urandom};
      srcMac = {$urandom, $urandom};
      nf = $urandom_range(1, 5);
      for (int f = 0; f < nf; f++) addFrame(k, 3'($urandom_range(0, 7)));
      runSequence(k, 2, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
